// File: rtl/turn_timer_ctrl_if.sv
// Shot-clock controller bus: game-side controls plus the
// strobes and status exchanged with the BCD down counter.
interface turn_timer_ctrl_if;
   logic       start_turn;
   logic       pause;
   logic       tc_in;
   logic [3:0] countH_in;
   logic       loadN;
   logic [3:0] datainL;
   logic [3:0] datainH;
   logic       enable1;
   logic       enable2;
   logic       turn_over;
   logic       warning;

   modport master (
      output start_turn,
      output pause,
      output tc_in,
      output countH_in,
      input  loadN,
      input  datainL,
      input  datainH,
      input  enable1,
      input  enable2,
      input  turn_over,
      input  warning
   );

   modport slave (
      input  start_turn,
      input  pause,
      input  tc_in,
      input  countH_in,
      output loadN,
      output datainL,
      output datainH,
      output enable1,
      output enable2,
      output turn_over,
      output warning
   );
endinterface

// File: rtl/turn_timer_ctrl.sv
// Billiard shot-clock control: loads the BCD down counter,
// paces it with a 1 Hz tick and flags expiry / low time.
module turn_timer_ctrl #(
   parameter int         TICK_DIV = 50_000_000,
   parameter logic [3:0] START_H  = 4'd3,
   parameter logic [3:0] START_L  = 4'd0,
   parameter logic [3:0] WARN_H   = 4'd1
) (
   input logic            clk,
   input logic            reset,
   turn_timer_ctrl_if.slave bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      EXPIRED
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [PW-1:0] presc;
   logic          run_en;
   logic          tick;
   logic          turn_over_q;
   logic          warning_q;
   logic          expire;

   // counter only advances while running and not paused
   assign run_en = (state == RUN) && !bus.pause;
   assign tick   = run_en && (presc == LAST);
   assign expire = (state == RUN) && (state_nx == EXPIRED);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state: restart beats expiry while running
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (bus.start_turn) state_nx = LOAD;
         end
         LOAD: begin
            state_nx = RUN;
         end
         RUN: begin
            if (bus.start_turn) begin
               state_nx = LOAD;
            end else if (bus.tc_in) begin
               state_nx = EXPIRED;
            end
         end
         EXPIRED: begin
            if (bus.start_turn) state_nx = LOAD;
         end
         default: state_nx = IDLE;
      endcase
   end

   // prescaler: cleared on load, frozen while paused
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else if (state == LOAD) begin
         presc <= '0;
      end else if (run_en) begin
         if (tick) begin
            presc <= '0;
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   // registered expiry pulse and low-time flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         turn_over_q <= 1'b0;
         warning_q   <= 1'b0;
      end else begin
         turn_over_q <= expire;
         warning_q   <= (state == RUN)
                     && (bus.countH_in < WARN_H)
                     && !bus.tc_in;
      end
   end

   assign bus.loadN     = (state != LOAD);
   assign bus.datainL   = START_L;
   assign bus.datainH   = START_H;
   assign bus.enable1   = tick;
   assign bus.enable2   = run_en;
   assign bus.turn_over = turn_over_q;
   assign bus.warning   = warning_q;

endmodule

// File: doc/turn_timer_ctrl.md
# turn_timer_ctrl

Control stage for the two-digit BCD down counter used as the billiard shot clock. It generates the counter's load strobe, its preset digits, and its two enable inputs. The enables are a 1 Hz tick from a clock prescaler and a run gate that is held off while shooting is paused. It consumes the counter's terminal-count flag and high digit, and produces a one-cycle turn-over pulse and a low-time warning flag for game logic and display.

## Interface
- TICK_DIV, 50_000_000, clk cycles per one-second tick (≥2)
- START_H, 4'd3, preset tens digit (BCD 0–9)
- START_L, 4'd0, preset units digit (BCD 0–9)
- WARN_H, 4'd1, warning asserted while counter tens digit < WARN_H
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- start_turn  in  1  synchronous pulse: (re)start turn timer
- pause  in  1  level: freeze timer (balls moving / menu)
- tc_in  in  1  counter terminal count (count == 00)
- countH_in  in  4  counter tens digit
- loadN  out  1  counter load strobe, active-low
- datainL  out  4  preset units digit = START_L (constant)
- datainH  out  4  preset tens digit = START_H (constant)
- enable1  out  1  one-second tick to counter
- enable2  out  1  run gate to counter
- turn_over  out  1  one-cycle pulse on expiry
- warning  out  1  low-time flag, registered

## Operation
- States: IDLE, LOAD, RUN, EXPIRED. Reset state is IDLE.
- IDLE:
  - start_turn → LOAD.
  - pause and tc_in are ignored.
- LOAD:
  - Lasts exactly 1 cycle with loadN=0.
  - The prescaler clears to 0.
  - The next state is always RUN; start_turn is ignored here.
  - tc_in is ignored because the counter still holds its old value.
- RUN, in priority order:
  - start_turn → LOAD. This restarts the turn; no turn_over is issued.
  - Else tc_in=1 → EXPIRED.
  - Else stay in RUN.
- EXPIRED:
  - enable1=0 and enable2=0.
  - start_turn → LOAD.
- Prescaler:
  - Width is $clog2(TICK_DIV).
  - It increments only when state==RUN and pause==0.
  - It wraps from TICK_DIV-1 to 0.
  - It holds its value, without clearing, while paused.
- enable1 = (state==RUN) & !pause & (prescaler==TICK_DIV-1). This is combinational from registers.
- enable2 = (state==RUN) & !pause.
- turn_over:
  - Registered. It is 1 for exactly the first cycle in EXPIRED, i.e. set on the RUN→EXPIRED edge and cleared on the next edge.
- warning:
  - Registered. Next value = (state==RUN) & (countH_in < WARN_H) & !tc_in.
  - It deasserts 1 cycle after leaving RUN.
- Preset 00: RUN sees tc_in=1 on its first cycle, so it expires immediately and turn_over pulses once.
- Simultaneous start_turn and pause in RUN: the load occurs. After LOAD, the counter holds its preset until pause drops.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous). After release the block stays in IDLE regardless of tc_in.

## Timing
- Reset values:
  - State IDLE, prescaler 0.
  - loadN=1, enable1=0, enable2=0, turn_over=0, warning=0.
  - datainL/datainH are constant presets.
- start_turn sampled at edge k:
  - LOAD (loadN=0) during cycle k..k+1.
  - The counter loads at edge k+1.
  - RUN from cycle k+1.
- The first enable1 occurs in the TICK_DIV-th unpaused RUN cycle; subsequent ticks follow every TICK_DIV unpaused cycles.
- Preset N (BCD value): tc_in rises after N ticks. turn_over is high in the cycle following the first RUN cycle with tc_in=1.
- Pausing for P cycles delays expiry by exactly P cycles.
- Integration: the counter's active-low reset is driven with ~reset.

## Test plan
Bench uses TICK_DIV=4, START_H=1, START_L=2, WARN_H=1, connected to the BCD down counter.
- Reset: assert reset mid-cycle → all outputs at reset values asynchronously. Release → IDLE; toggling tc_in produces no turn_over.
- Full turn:
  - Stimulus: start_turn pulse.
  - loadN is low for 1 cycle and the count becomes 12.
  - enable1 pulses every 4 cycles and the count steps 12→11→…→00.
  - warning rises 1 cycle after the count reaches 09.
  - turn_over is a single 1-cycle pulse 1 cycle after the count reaches 00 (48 RUN cycles after load).
  - warning falls 1 cycle after tc.
- Pause: hold pause for 10 cycles at count 07 with prescaler=2.
  - No enable1 and enable2=0 throughout; the count stays at 07.
  - The next tick comes 2 unpaused cycles after release.
  - turn_over is delayed by exactly 10 cycles versus the full-turn case.
- Restart in RUN: start_turn at count 05.
  - Reload to 12 and the prescaler clears.
  - warning drops; no turn_over is generated.
  - Expiry occurs 48 RUN cycles after the new load.
- start_turn with pause high, from EXPIRED:
  - LOAD occurs and the count becomes 12.
  - enable2=0 until pause drops, and the count holds at 12.
- Preset 00 (START_H=0, START_L=0): start_turn → LOAD → RUN for 1 cycle → EXPIRED. Exactly one turn_over pulse and no enable1.
